// File: rtl/rom_writer.sv
// rom_writer - sequential memory loader.
//
// Accepts a byte stream over a valid/ready handshake. It packs bytes
// little-endian into WIDTH-bit words and writes each word to consecutive
// addresses of a synchronous RAM, starting at address 0. A load stops after
// NWORDS words. The display ROM fetcher later reads the image back by
// sequential PC.
//
// Optional feature: define ROM_WRITER_CHECKSUM_EN to get a running mod-256
// byte sum on `checksum`. When the macro is undefined, `checksum` is tied
// to 0 and no adder is built.
//
// Parameters
//   WIDTH   word width in bits, a multiple of 8 in the range 8..32
//   ADDR_W  address width
//   NWORDS  words per load, 1..2^ADDR_W
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a load (sampled in IDLE and DONE only)
//   in_data    byte from the source
//   in_valid   in_data is valid
//   in_ready   a byte is accepted this cycle (decoded from state)
//   mem_we     one-cycle RAM write strobe
//   mem_addr   RAM write address
//   mem_wdata  RAM write data
//   busy       loading (FILL or WRITE; decoded from state)
//   done       load complete; held until the next start
//   checksum   running byte sum since the last start (or 0)
module rom_writer #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8,
  parameter int NWORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [7:0]        checksum
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int                BYTES     = WIDTH / 8;
  localparam logic [2:0]        LAST_BYTE = 3'(BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NWORDS - 1);

  logic [1:0] state;
  logic [2:0] byte_cnt;
  logic       accept;
  logic       load_start;

  assign in_ready   = (state == FILL);
  assign busy       = (state == FILL) || (state == WRITE);
  assign accept     = in_valid && in_ready;
  assign load_start = start && ((state == IDLE) || (state == DONE));

  // NOTE: sequential state uses non-blocking assignments only. Every flop in
  // the block then updates from the same pre-edge values, whatever order the
  // statements appear in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
    end else begin
      // The write strobe is a single-cycle pulse. It defaults low and is
      // raised only on the edge that enters WRITE.
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FILL;
            mem_addr <= '0;
            byte_cnt <= '0;
          end
        end
        FILL: begin
          if (accept) begin
            // The word is assembled in place in mem_wdata. Its value only
            // matters while mem_we is high, and it holds steady through WRITE.
            for (int k = 0; k < BYTES; k++) begin
              if (byte_cnt == 3'(k)) mem_wdata[8*k +: 8] <= in_data;
            end
            if (byte_cnt == LAST_BYTE) begin
              state  <= WRITE;
              mem_we <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        WRITE: begin
          if (mem_addr == LAST_ADDR) begin
            // Address holds at NWORDS-1. It never wraps within a load.
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= FILL;
            mem_addr <= mem_addr + ADDR_W'(1);
            byte_cnt <= '0;
          end
        end
        DONE: begin
          if (start) begin
            state    <= FILL;
            done     <= 1'b0;
            mem_addr <= '0;
            byte_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROM_WRITER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= 8'h00;
    end else if (load_start) begin
      checksum <= 8'h00;
    end else if (accept) begin
      checksum <= checksum + in_data;
    end
  end
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_rom_writer.sv
// tb_rom_writer - scoreboard bench for rom_writer (WIDTH=16, NWORDS=4).
//
// Stimulus tasks push the hand-computed expected writes into exp_q. A
// monitor process pops one entry on every mem_we cycle and compares it with
// the DUT outputs. Checksum expectations follow ROM_WRITER_CHECKSUM_EN.
module tb_rom_writer;

  localparam int WIDTH  = 16;
  localparam int ADDR_W = 8;
  localparam int NWORDS = 4;

`ifdef ROM_WRITER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              busy;
  logic              done;
  logic [7:0]        checksum;

  rom_writer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NWORDS(NWORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  // Monitor controls.
  int cyc          = 0;
  bit spacing_on   = 1'b0;
  int last_we_cyc  = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] cs_exp(input logic [7:0] v);
    return CS_EN ? v : 8'h00;
  endfunction

  task automatic push_exp(input logic [7:0] a, input logic [15:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Drive tx_q one byte at a time. Each byte is held until it is accepted.
  // With gaps set, in_valid is randomized. start is also raised while byte
  // index start_idx is on offer; the block is in FILL at that point, so the
  // pulse must be ignored.
  task automatic send_bytes(input bit gaps, input int start_idx);
    int i = 0;
    int guard = 0;
    while (i < tx_q.size()) begin
      @(negedge clk);
      in_data  = tx_q[i];
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      start    = (i == start_idx) && in_ready;
      if (in_valid && in_ready) begin
        i++;
        guard = 0;
      end else if (++guard > 50) begin
        check("byte_accept_timeout", 32'(i), 32'(tx_q.size()));
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("in_ready_after_start", in_ready, 1);
    check("done_after_start", done, 0);
  endtask

  task automatic wait_done(input logic [7:0] cs);
    for (int k = 0; k < 100 && !done; k++) @(negedge clk);
    check("done_reached", done, 1);
    check("busy_in_done", busy, 0);
    check("in_ready_in_done", in_ready, 0);
    check("addr_held_in_done", mem_addr, NWORDS - 1);
    check("checksum_in_done", checksum, cs);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_checksum"}, checksum, 0);
  endtask

  task automatic fill_seq(input logic [7:0] first, input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(first + 8'(i));
  endtask

  // Scoreboard monitor. It samples on the falling edge, away from the
  // active edge.
  bit prev_we       = 1'b0;
  bit final_pending = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (final_pending) begin
        check("done_after_last_write", done, 1);
        final_pending = 1'b0;
      end
      if (mem_we) begin
        check("mem_we_one_cycle", prev_we, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", mem_addr, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("write_addr", mem_addr, e.addr);
          check("write_data", mem_wdata, e.data);
          if (e.addr == 8'(NWORDS - 1)) final_pending = 1'b1;
        end
        if (spacing_on && last_we_cyc >= 0) check("write_spacing", cyc - last_we_cyc, 3);
        last_we_cyc = cyc;
      end
      prev_we = mem_we;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] basic_w  [4] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
  logic [15:0] reload_w [4] = '{16'h1110, 16'h1312, 16'h1514, 16'h1716};

  initial begin
    // Reset with random inputs.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start    = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
    end
    check_reset_outputs("reset");
    start    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 0);
    check("idle_busy", busy, 0);

    // Basic load: bytes 01..08 with in_valid held high.
    start_pulse();
    check("busy_in_fill", busy, 1);
    for (int w = 0; w < 4; w++) push_exp(8'(w), basic_w[w]);
    fill_seq(8'h01, 8);
    last_we_cyc = -1;
    spacing_on  = 1'b1;
    send_bytes(1'b0, -1);
    wait_done(cs_exp(8'h24));
    spacing_on = 1'b0;

    // Backpressure: same data with random in_valid gaps.
    start_pulse();
    for (int w = 0; w < 4; w++) push_exp(8'(w), basic_w[w]);
    send_bytes(1'b1, -1);
    wait_done(cs_exp(8'h24));

    // Reset mid-word: two words written, then 0xAA is accepted and reset hits.
    start_pulse();
    push_exp(8'd0, 16'h0201);
    push_exp(8'd1, 16'h0403);
    fill_seq(8'h01, 4);
    tx_q.push_back(8'hAA);
    send_bytes(1'b0, -1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_pending_after_reset", exp_q.size(), 0);
    start_pulse();
    for (int w = 0; w < 4; w++) push_exp(8'(w), basic_w[w]);
    fill_seq(8'h01, 8);
    send_bytes(1'b0, -1);
    wait_done(cs_exp(8'h24));

    // Reload from DONE with bytes 10..17; start pulsed again during FILL.
    start_pulse();
    for (int w = 0; w < 4; w++) push_exp(8'(w), reload_w[w]);
    fill_seq(8'h10, 8);
    send_bytes(1'b0, 1);
    wait_done(cs_exp(8'h9C));

    // Checksum pattern: 0xFF, 0x02 repeated four times.
    start_pulse();
    check("checksum_cleared_on_start", checksum, 0);
    tx_q.delete();
    for (int w = 0; w < 4; w++) begin
      tx_q.push_back(8'hFF);
      tx_q.push_back(8'h02);
      push_exp(8'(w), 16'h02FF);
    end
    send_bytes(1'b1, -1);
    wait_done(cs_exp(8'h04));

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("done_still_held", done, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
